// File: rtl/gpu_cmd_pkg.sv
// Shared constants for the host command link return path: command bit
// indices, packet framing bytes, response type codes and FSM state encodings.
package gpu_cmd_pkg;

   // Command decoder vector layout
   localparam int NUM_SRC_DEF    = 8;
   localparam int CMD_BIT_STATUS = 7;
   localparam int IDX_W          = 3;

   // Framing
   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   // Response type codes carried in the upper nibble of the header byte
   localparam logic [3:0] TYPE_DONE   = 4'h1;
   localparam logic [3:0] TYPE_STATUS = 4'h2;

   // Packetizer FSM encodings
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_SYNC = 3'd1;
   localparam logic [2:0] ST_HDR  = 3'd2;
   localparam logic [2:0] ST_PAY  = 3'd3;
   localparam logic [2:0] ST_CSUM = 3'd4;

   typedef struct packed {
      logic [3:0]       typ;
      logic             ovf;
      logic [IDX_W-1:0] idx;
   } hdr_t;

   // Assemble the header byte {TYPE, ovf_snap, IDX}
   function automatic logic [7:0] make_hdr(input logic [3:0] typ, input logic ovf,
                                           input logic [IDX_W-1:0] idx);
      hdr_t h;
      h.typ = typ;
      h.ovf = ovf;
      h.idx = idx;
      return h;
   endfunction

endpackage

// File: rtl/resp_arbiter.sv
// Sticky pending bits for DONE and STATUS events, lost-event detection and
// fixed-priority selection (STATUS first, then lowest DONE index).
// A one-cycle take strobe from the packetizer consumes the selected event.
module resp_arbiter
   import gpu_cmd_pkg::*;
#(
   parameter int NUM_SRC = NUM_SRC_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_SRC-1:0] done,
   input  logic               stat_req,
   input  logic               take,
   output logic               sel_valid,
   output logic               sel_stat,
   output logic [IDX_W-1:0]   sel_idx,
   output logic               ovf
);

   logic [NUM_SRC-1:0] pend_done;
   logic               pend_stat;
   logic [NUM_SRC-1:0] consume_done;
   logic               consume_stat;
   logic [NUM_SRC-1:0] loss;
   logic               lost_any;

   // Priority select: lowest pending DONE index wins (loop runs high to low)
   always_comb begin
      sel_idx = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (pend_done[i]) sel_idx = IDX_W'(i);
      end
   end

   assign sel_stat  = pend_stat;
   assign sel_valid = pend_stat | (|pend_done);

   // Consume masks: STATUS has priority, so a DONE bit is only consumed when no STATUS is pending
   always_comb begin
      consume_stat = take & pend_stat;
      consume_done = '0;
      if (take && !pend_stat && (|pend_done)) begin
         consume_done = {{(NUM_SRC-1){1'b0}}, 1'b1} << sel_idx;
      end
   end

   // A pulse on an already-pending DONE bit that is not leaving this cycle is a lost event
   assign loss     = done & pend_done & ~consume_done;
   assign lost_any = |loss;

   // Pending registers: set dominates clear; ovf restarts at each latch unless a loss coincides
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_done <= '0;
         pend_stat <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         pend_done <= (pend_done & ~consume_done) | done;
         pend_stat <= (pend_stat & ~consume_stat) | stat_req;
         ovf       <= take ? lost_any : (ovf | lost_any);
      end
   end

endmodule

// File: rtl/resp_packetizer.sv
// Response packetizer: frames arbitrated DONE/STATUS events as
// SYNC/HDR/PAY[/CSUM] bytes on a valid/ready byte stream toward the UART TX.
// Build option: define RESP_CHECKSUM_EN for 4-byte packets with CSUM = HDR ^ PAY;
// otherwise packets are 3 bytes.
//
// Handshake: a byte transfers on a rising CLK edge where tx_valid && tx_ready.
// Once tx_valid is high, tx_data and tx_valid hold until that transfer happens.
module resp_packetizer
   import gpu_cmd_pkg::*;
#(
   parameter int         NUM_SRC    = NUM_SRC_DEF,
   parameter int         STATUS_BIT = CMD_BIT_STATUS,
   parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
   input  logic               CLK,
   input  logic               rst_n,
   input  logic [NUM_SRC-1:0] CMD,
   input  logic [NUM_SRC-1:0] BUSY,
   input  logic [NUM_SRC-1:0] DONE,
   input  logic               tx_ready,
   output logic [7:0]         tx_data,
   output logic               tx_valid,
   output logic               pkt_busy,
   output logic               ovf,
   output logic [2:0]         state_dbg
);

   logic [2:0]       state;
   logic [7:0]       hdr_q;
   logic [7:0]       pay_q;
   logic [7:0]       seq;
   logic             sel_valid;
   logic             sel_stat;
   logic [IDX_W-1:0] sel_idx;
   logic             take;
   logic             hs;
   logic             last_byte;
   logic             unused_cmd;

   // Only the STATUS bit of the command vector matters here
   assign unused_cmd = ^CMD;

   resp_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
      .clk       (CLK),
      .rst_n     (rst_n),
      .done      (DONE),
      .stat_req  (CMD[STATUS_BIT]),
      .take      (take),
      .sel_valid (sel_valid),
      .sel_stat  (sel_stat),
      .sel_idx   (sel_idx),
      .ovf       (ovf)
   );

   assign take     = (state == ST_IDLE) && sel_valid;
   assign tx_valid = (state != ST_IDLE);
   assign hs       = tx_valid && tx_ready;

`ifdef RESP_CHECKSUM_EN
   assign last_byte = (state == ST_CSUM);
`else
   assign last_byte = (state == ST_PAY);
`endif

   // Packet FSM with header/payload latch at the IDLE->SYNC transition
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         hdr_q <= '0;
         pay_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (take) begin
                  if (sel_stat) begin
                     hdr_q <= make_hdr(TYPE_STATUS, ovf, IDX_W'(STATUS_BIT));
                     pay_q <= BUSY;
                  end else begin
                     hdr_q <= make_hdr(TYPE_DONE, ovf, sel_idx);
                     pay_q <= seq;
                  end
                  state <= ST_SYNC;
               end
            end
            ST_SYNC: if (hs) state <= ST_HDR;
            ST_HDR:  if (hs) state <= ST_PAY;
`ifdef RESP_CHECKSUM_EN
            ST_PAY:  if (hs) state <= ST_CSUM;
            ST_CSUM: if (hs) state <= ST_IDLE;
`else
            ST_PAY:  if (hs) state <= ST_IDLE;
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Sequence number advances once per completed packet, wrapping naturally
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         seq <= '0;
      end else if (hs && last_byte) begin
         seq <= seq + 8'd1;
      end
   end

   // pkt_busy spans packet latch through the final byte transfer
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         pkt_busy <= 1'b0;
      end else if (take) begin
         pkt_busy <= 1'b1;
      end else if (hs && last_byte) begin
         pkt_busy <= 1'b0;
      end
   end

   // Output byte mux driven purely from registered state
   always_comb begin
      tx_data = 8'h00;
      case (state)
         ST_SYNC: tx_data = SYNC_BYTE;
         ST_HDR:  tx_data = hdr_q;
         ST_PAY:  tx_data = pay_q;
`ifdef RESP_CHECKSUM_EN
         ST_CSUM: tx_data = hdr_q ^ pay_q;
`endif
         default: tx_data = 8'h00;
      endcase
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_resp_packetizer.sv
// Self-checking bench for resp_packetizer: expected packet bytes are pushed
// into a queue when events are driven and popped as the DUT hands bytes over.
// Honours RESP_CHECKSUM_EN for packet length and checksum byte.
module tb_resp_packetizer;

`ifdef RESP_CHECKSUM_EN
   localparam int PKT_LEN = 4;
`else
   localparam int PKT_LEN = 3;
`endif

   logic       CLK;
   logic       rst_n;
   logic [7:0] CMD;
   logic [7:0] BUSY;
   logic [7:0] DONE;
   logic       tx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       pkt_busy;
   logic       ovf;
   logic [2:0] state_dbg;

   logic [7:0] exp_q[$];
   logic [7:0] exp_seq;
   int         n_checks;
   int         n_pass;

   // Monitor state
   int         byte_pos;
   int         pkts_out;
   int         idle_run;
   logic       prev_valid;
   logic       prev_stall;
   logic [7:0] prev_data;
   logic       b2b_armed;
   int         b2b_base;

   resp_packetizer dut (
      .CLK       (CLK),
      .rst_n     (rst_n),
      .CMD       (CMD),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .tx_ready  (tx_ready),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .pkt_busy  (pkt_busy),
      .ovf       (ovf),
      .state_dbg (state_dbg)
   );

   // Clock
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic push_pkt(input logic [3:0] typ, input logic ovf_b, input logic [2:0] idx,
                           input logic [7:0] pay);
      logic [7:0] hdr;
      hdr = {typ, ovf_b, idx};
      exp_q.push_back(8'hA5);
      exp_q.push_back(hdr);
      exp_q.push_back(pay);
`ifdef RESP_CHECKSUM_EN
      exp_q.push_back(hdr ^ pay);
`endif
      exp_seq = exp_seq + 8'd1;
   endtask

   task automatic push_done(input logic [2:0] idx, input logic ovf_b);
      push_pkt(4'h1, ovf_b, idx, exp_seq);
   endtask

   task automatic push_stat(input logic [7:0] busy_v, input logic ovf_b);
      push_pkt(4'h2, ovf_b, 3'd7, busy_v);
   endtask

   // Drive one-cycle pulses; called and returns at posedge+1
   task automatic pulse(input logic [7:0] done_v, input logic [7:0] cmd_v);
      DONE = done_v;
      CMD  = cmd_v;
      @(posedge CLK); #1;
      DONE = 8'h00;
      CMD  = 8'h00;
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK); #1;
      end
   endtask

   // Run until all expected bytes are out and the link is idle
   task automatic wait_drain(input logic rand_ready);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || tx_valid) && n < 2000) begin
         @(posedge CLK); #1;
         if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
         n++;
      end
      if (n >= 2000) check("drain_timeout", 32'(exp_q.size()), 0);
      tx_ready = 1'b1;
      step(2);
   endtask

   // Scoreboard monitor, sampled on the falling edge
   always @(negedge CLK) begin
      if (!rst_n) begin
         byte_pos   = 0;
         prev_stall = 1'b0;
         prev_valid = 1'b0;
         idle_run   = 0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", 32'(tx_valid), 1);
            check("stall_data", 32'(tx_data), 32'(prev_data));
         end
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
               check("extra_byte", 32'(tx_data), 32'hFFFF_FFFF);
            end else begin
               check("byte", 32'(tx_data), 32'(exp_q.pop_front()));
            end
            byte_pos++;
            if (byte_pos == PKT_LEN) begin
               byte_pos = 0;
               pkts_out++;
            end
         end
         if (tx_valid && !prev_valid && b2b_armed && pkts_out == b2b_base + 1) begin
            check("b2b_gap", 32'(idle_run), 1);
            b2b_armed = 1'b0;
         end
         idle_run   = tx_valid ? 0 : idle_run + 1;
         prev_valid = tx_valid;
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
      end
   end

   initial begin
      logic [7:0] busy_v;
      int         r;
      int         ia;
      int         ib;
      n_checks  = 0;
      n_pass    = 0;
      exp_seq   = 8'h00;
      pkts_out  = 0;
      b2b_armed = 1'b0;
      b2b_base  = 0;
      byte_pos  = 0;
      rst_n     = 1'b0;
      CMD       = 8'h00;
      BUSY      = 8'h00;
      DONE      = 8'h00;
      tx_ready  = 1'b1;

      // Reset state
      step(3);
      check("rst_tx_valid", 32'(tx_valid), 0);
      check("rst_tx_data", 32'(tx_data), 0);
      check("rst_pkt_busy", 32'(pkt_busy), 0);
      check("rst_ovf", 32'(ovf), 0);
      rst_n = 1'b1;
      step(2);

      // Single DONE[2]: two-cycle latency to SYNC, A5 12 00
      push_done(3'd2, 1'b0);
      pulse(8'h04, 8'h00);
      check("t1_lat_c1_valid", 32'(tx_valid), 0);
      step(1);
      check("t1_lat_c2_valid", 32'(tx_valid), 1);
      check("t1_lat_c2_data", 32'(tx_data), 32'hA5);
      check("t1_pkt_busy_on", 32'(pkt_busy), 1);
      wait_drain(1'b0);
      check("t1_pkt_busy_off", 32'(pkt_busy), 0);

      // STATUS with BUSY snapshot
      BUSY = 8'h14;
      push_stat(8'h14, 1'b0);
      pulse(8'h00, 8'h80);
      wait_drain(1'b0);

      // Two DONEs in one cycle: IDX 1 then IDX 4 with one idle cycle between
      push_done(3'd1, 1'b0);
      push_done(3'd4, 1'b0);
      b2b_base  = pkts_out;
      b2b_armed = 1'b1;
      pulse(8'h12, 8'h00);
      wait_drain(1'b0);
      check("t3_b2b_seen", 32'(b2b_armed), 0);

      // Lost event while stalled: ovf set, snapped into next header, then cleared
      tx_ready = 1'b0;
      push_done(3'd0, 1'b0);
      pulse(8'h01, 8'h00);
      step(1);
      pulse(8'h08, 8'h00);
      step(1);
      check("t4_ovf_clear_before", 32'(ovf), 0);
      pulse(8'h08, 8'h00);
      check("t4_ovf_set", 32'(ovf), 1);
      push_done(3'd3, 1'b1);
      step(3);
      tx_ready = 1'b1;
      wait_drain(1'b0);
      check("t4_ovf_cleared", 32'(ovf), 0);

      // Payload equal to the SYNC byte
      BUSY = 8'hA5;
      push_stat(8'hA5, 1'b0);
      pulse(8'h00, 8'h80);
      wait_drain(1'b1);

      // Random ready with mixed events; long enough to wrap seq
      for (int it = 0; it < 260; it++) begin
         r = $urandom_range(0, 3);
         if (r == 0) begin
            busy_v = 8'($urandom_range(0, 255));
            BUSY   = busy_v;
            push_stat(busy_v, 1'b0);
            pulse(8'h00, 8'h80);
         end else begin
            ia = $urandom_range(0, 7);
            push_done(3'(ia), 1'b0);
            pulse(8'h01 << ia, 8'h00);
         end
         wait_drain(1'b1);
      end

      // Burst: STATUS plus two DONEs at once, random ready
      ia = $urandom_range(0, 3);
      ib = $urandom_range(4, 7);
      BUSY = 8'h3C;
      push_stat(8'h3C, 1'b0);
      push_done(3'(ia), 1'b0);
      push_done(3'(ib), 1'b0);
      pulse((8'h01 << ia) | (8'h01 << ib), 8'h80);
      wait_drain(1'b1);

      // Reset during HDR abandons the packet and clears pending DONE[6]
      tx_ready = 1'b1;
      push_done(3'd5, 1'b0);
      pulse(8'h60, 8'h00);
      step(2);
      check("t6_hdr_before_rst", 32'(tx_data), 32'h15);
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", 32'(tx_valid), 0);
      check("t6_rst_pkt_busy", 32'(pkt_busy), 0);
      exp_q.delete();
      exp_seq = 8'h00;
      @(posedge CLK); #1;
      rst_n = 1'b1;
      step(4);
      check("t6_pend_cleared", 32'(tx_valid), 0);
      push_done(3'd0, 1'b0);
      pulse(8'h01, 8'h00);
      wait_drain(1'b0);
      check("t6_queue_empty", 32'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
